axi_lite_reg_slave: RTL and testbench

AXI4-Lite slave register bank that sits directly downstream of the AXI4-Lite master interface. It accepts write-address, write-data and read-address transactions and applies byte strobes to a small register file. It returns OKAY, SLVERR or DECERR responses. It is the DUT endpoint the master driver and monitor exercise.

---
 rtl/axi_lite_pkg.sv | 39 +++
 rtl/axi_lite_regbank.sv | 52 +++++
 rtl/axi_lite_reg_slave.sv | 175 +++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared AXI4-Lite widths, response encoding and address decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Classify an address against a word-addressed window of num_regs registers.
    // An out-of-window address is DECERR even when it is also misaligned.
    function automatic resp_t decode_resp(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] num_regs
    );
        logic [ADDR_W-1:0] off;
        off = addr - base;
        if ((addr < base) || ((off >> 2) >= num_regs)) begin
            return DECERR;
        end
        if (addr[1:0] != 2'b00) begin
            return SLVERR;
        end
        return OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_regbank
//  Description : Register array with one byte-strobed write port and one
//                combinational read port; index 0 reads a fixed ID value.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int                NUM_REGS = 16,
    parameter int                IDX_W    = 4,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'hA11C_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Clear on reset; otherwise merge strobed bytes into the addressed register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_widx != '0)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_regs[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Index 0 is the hardwired ID register; storage slot 0 is never written.
    always_comb begin
        if (i_ridx == '0) begin
            o_rdata = ID_VALUE;
        end else begin
            o_rdata = r_regs[i_ridx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_reg_slave
//  Description : AXI4-Lite slave register bank. Independent AW/W capture, one
//                outstanding write and one outstanding read, OKAY/SLVERR/DECERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [DATA_W-1:0] ID_VALUE  = 32'hA11C_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] c_NUM_REGS = ADDR_W'(NUM_REGS);

    localparam logic [0:0] c_W_IDLE = 1'b0;
    localparam logic [0:0] c_W_RESP = 1'b1;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_RESP = 1'b1;

    logic [0:0]        r_wstate;
    logic [0:0]        r_rstate;
    logic              r_aw_have;
    logic              r_w_have;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;

    logic [IDX_W-1:0]  w_aw_idx;
    logic [IDX_W-1:0]  w_ar_idx;
    resp_t             w_wr_resp;
    resp_t             w_rd_resp;
    logic              w_commit;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_data;

    assign w_aw_idx = IDX_W'((r_awaddr - BASE_ADDR) >> 2);
    assign w_ar_idx = IDX_W'((araddr - BASE_ADDR) >> 2);
    assign w_rd_resp = decode_resp(araddr, BASE_ADDR, c_NUM_REGS);
    assign w_commit = (r_wstate == c_W_IDLE) && r_aw_have && r_w_have;
    assign w_we     = w_commit && (w_wr_resp == OKAY);

    // Write decode: the ID register is read-only, so a write to it is SLVERR.
    always_comb begin
        w_wr_resp = decode_resp(r_awaddr, BASE_ADDR, c_NUM_REGS);
        if ((w_wr_resp == OKAY) && (w_aw_idx == '0)) begin
            w_wr_resp = SLVERR;
        end
    end

    axi_lite_regbank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_widx  (w_aw_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_ridx  (w_ar_idx),
        .o_rdata (w_rd_data)
    );

    // Write FSM: capture AW and W independently, commit once both are held,
    // then present the response until the master takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= c_W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= OKAY;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    if (w_commit) begin
                        bresp     <= w_wr_resp;
                        bvalid    <= 1'b1;
                        r_aw_have <= 1'b0;
                        r_w_have  <= 1'b0;
                        r_wstate  <= c_W_RESP;
                    end else begin
                        if (awvalid && awready) begin
                            r_awaddr  <= awaddr;
                            r_aw_have <= 1'b1;
                            awready   <= 1'b0;
                        end else if (!r_aw_have) begin
                            awready   <= 1'b1;
                        end
                        if (wvalid && wready) begin
                            r_wdata  <= wdata;
                            r_wstrb  <= wstrb;
                            r_w_have <= 1'b1;
                            wready   <= 1'b0;
                        end else if (!r_w_have) begin
                            wready   <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bvalid && bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        r_wstate <= c_W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read FSM: the AR handshake edge loads the response from pre-edge contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= c_R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= OKAY;
            rdata    <= '0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (arvalid && arready) begin
                        rdata    <= (w_rd_resp == OKAY) ? w_rd_data : '0;
                        rresp    <= w_rd_resp;
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        r_rstate <= c_R_RESP;
                    end else begin
                        arready  <= 1'b1;
                    end
                end
                default: begin
                    if (rvalid && rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        r_rstate <= c_R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_reg_slave
//  Description : Self-checking bench for axi_lite_reg_slave with a behavioural
//                register-file model and randomized transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_slave;

    localparam int          NREG = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] IDV  = 32'hA11C_0001;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [NREG];

    axi_lite_reg_slave #(
        .NUM_REGS  (NREG),
        .BASE_ADDR (BASE),
        .ID_VALUE  (IDV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference response rules, expressed on the byte address.
    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input bit is_wr);
        longint off;
        if (addr < BASE) return 2'b11;
        off = longint'(addr) - longint'(BASE);
        if (off / 4 >= NREG) return 2'b11;
        if (off % 4 != 0) return 2'b10;
        if (is_wr && (off / 4 == 0)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        int idx;
        if (exp_resp(addr, 1'b0) != 2'b00) return 32'h0;
        idx = int'((addr - BASE) / 4);
        if (idx == 0) return IDV;
        return model[idx];
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        if (exp_resp(addr, 1'b1) == 2'b00) begin
            idx = int'((addr - BASE) / 4);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input bit rd_same, input bit rst_pending);
        logic [1:0]  er;
        logic [31:0] old_rd;
        logic [1:0]  old_rr;
        bit          aw_done;
        bit          w_done;
        bit          hs_aw;
        bit          hs_w;
        int          t;
        aw_done = 1'b0;
        w_done  = 1'b0;
        t       = 0;
        er      = exp_resp(addr, 1'b1);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        while (!(aw_done && w_done) && t < 40) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            hs_aw   = awvalid && awready;
            hs_w    = wvalid && wready;
            tick();
            if (hs_aw) aw_done = 1'b1;
            if (hs_w)  w_done  = 1'b1;
            t++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_handshake", {31'b0, aw_done && w_done}, 32'd1);
        check("bvalid_after_hs", {31'b0, bvalid}, 32'd0);
        if (rd_same) begin
            old_rd  = exp_rdata(addr);
            old_rr  = exp_resp(addr, 1'b0);
            araddr  = addr;
            arvalid = 1'b1;
            rready  = 1'b1;
            check("arready_same_edge", {31'b0, arready}, 32'd1);
        end
        bready = (b_dly == 0) && !rst_pending;
        tick();
        if (rd_same) begin
            arvalid = 1'b0;
            check("rvalid_same_edge", {31'b0, rvalid}, 32'd1);
            check("rdata_same_edge_old", rdata, old_rd);
            check("rresp_same_edge", {30'b0, rresp}, {30'b0, old_rr});
        end
        model_write(addr, data, strb);
        check("bvalid_latency", {31'b0, bvalid}, 32'd1);
        check("bresp", {30'b0, bresp}, {30'b0, er});
        check("awready_in_resp", {31'b0, awready}, 32'd0);
        if (rst_pending) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            model_reset();
            check("bvalid_after_rst", {31'b0, bvalid}, 32'd0);
            check("awready_in_rst", {31'b0, awready}, 32'd0);
            check("wready_in_rst", {31'b0, wready}, 32'd0);
            tick();
            check("awready_after_rst", {31'b0, awready}, 32'd1);
            check("wready_after_rst", {31'b0, wready}, 32'd1);
            check("arready_after_rst", {31'b0, arready}, 32'd1);
            rready = 1'b0;
            return;
        end
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check("bvalid_hold", {31'b0, bvalid}, 32'd1);
            check("bresp_hold", {30'b0, bresp}, {30'b0, er});
            check("awready_hold", {31'b0, awready}, 32'd0);
            check("wready_hold", {31'b0, wready}, 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        check("bvalid_cleared", {31'b0, bvalid}, 32'd0);
        check("awready_back", {31'b0, awready}, 32'd1);
        check("wready_back", {31'b0, wready}, 32'd1);
    endtask

    task automatic read_txn(input logic [31:0] addr, input int r_dly);
        logic [1:0]  er;
        logic [31:0] ed;
        int          t;
        er      = exp_resp(addr, 1'b0);
        ed      = exp_rdata(addr);
        araddr  = addr;
        arvalid = 1'b1;
        t       = 0;
        while (!arready && t < 20) begin
            tick();
            t++;
        end
        check("arready_wait", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        check("rvalid", {31'b0, rvalid}, 32'd1);
        check("rdata", rdata, ed);
        check("rresp", {30'b0, rresp}, {30'b0, er});
        check("arready_in_resp", {31'b0, arready}, 32'd0);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check("rvalid_hold", {31'b0, rvalid}, 32'd1);
            check("rdata_hold", rdata, ed);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_cleared", {31'b0, rvalid}, 32'd0);
        check("arready_back", {31'b0, arready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        rst     = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready", {31'b0, wready}, 32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_bresp", {30'b0, bresp}, 32'd0);
        check("rst_rresp", {30'b0, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        check("awready_rise", {31'b0, awready}, 32'd1);
        check("wready_rise", {31'b0, wready}, 32'd1);
        check("arready_rise", {31'b0, arready}, 32'd1);

        // Directed cases
        read_txn(32'h0, 0);
        write_txn(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0, 1'b0);
        read_txn(32'h4, 1);
        write_txn(32'h8, 32'h1234_5678, 4'b0101, 2, 0, 5, 1'b0, 1'b0);
        read_txn(32'h8, 0);
        write_txn(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, 1'b0, 1'b0);
        read_txn(32'h40, 0);
        write_txn(32'h0, 32'h5555_5555, 4'hF, 1, 0, 0, 1'b0, 1'b0);
        read_txn(32'h0, 0);
        read_txn(32'h6, 0);
        write_txn(32'h6, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, 1'b0, 1'b0);
        write_txn(32'h43, 32'h1111_1111, 4'hF, 0, 0, 0, 1'b0, 1'b0);
        write_txn(32'hC, 32'hCAFE_F00D, 4'b0000, 0, 0, 0, 1'b0, 1'b0);
        read_txn(32'hC, 0);
        write_txn(32'h4, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 1'b1, 1'b0);
        read_txn(32'h4, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 7) begin
                a = BASE + 32'($urandom_range(0, NREG - 1)) * 4;
            end else if (kind == 7) begin
                a = BASE + 32'($urandom_range(0, NREG - 1)) * 4 + 32'($urandom_range(1, 3));
            end else if (kind == 8) begin
                a = BASE + 32'($urandom_range(NREG, NREG + 100)) * 4 + 32'($urandom_range(0, 3));
            end else begin
                a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) == 1) begin
                write_txn(a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 1'b0, 1'b0);
            end else begin
                read_txn(a, int'($urandom_range(0, 2)));
            end
        end
        for (int i = 0; i < NREG; i++) begin
            read_txn(BASE + 32'(i) * 4, 0);
        end

        // Reset while a write response is pending
        write_txn(32'h10, 32'h7777_8888, 4'hF, 0, 0, 0, 1'b0, 1'b1);
        read_txn(32'h4, 0);
        read_txn(32'h10, 0);
        write_txn(32'h10, 32'h9999_AAAA, 4'b1100, 0, 0, 1, 1'b0, 1'b0);
        read_txn(32'h10, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
